uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Parameterised UART transmitter. On a `send` request it serialises one byte as 11 bits: start bit, 8 data bits LSB first, parity bit, stop bit.
- Line idles high.
- Sits between on-chip logic that produces bytes and the board-level serial TX pin.
- `busy` tells the producer when a new byte may be offered.

Parameters:
- CLK_FREQUENCY, 100_000_000: input clock frequency in Hz.
- BAUD_RATE, 19_200: serial bit rate in bits/s.
- PARITY, 0: 0 = even parity, 1 = odd parity. The parity bit is always transmitted.
- Derived localparam BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE, integer division. This gives 5208 at the defaults.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- send  input  1  transmit request, level-sensitive, sampled in IDLE.
- din  input  8  byte to transmit; sampled on the clock edge that accepts `send`.
- tx_out  output  1  serial line, registered; idle/stop = 1, start = 0.
- busy  output  1  high while a frame is in progress, registered.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-frame):
  - On the next rising edge: state=IDLE, tx_out=1, busy=0, baud counter=0, bit index=0.
  - Any partial frame is abandoned; the stop bit is not completed.
- State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If send=1 at a rising edge: latch din into a shift register, go to START, clear the baud counter.
  - tx_out=0 and busy=1 from that same edge. One-cycle latency from send sampled to start bit on line.
- START: drive 0 for BAUD_CLOCKS cycles, then go to DATA with bit index 0.
- DATA:
  - Drive din[index] for BAUD_CLOCKS cycles each, index 0..7.
  - After bit 7, go to PARITY.
- PARITY:
  - Drive ^din (XOR of the latched byte) when PARITY=0; drive ~^din when PARITY=1.
  - Either way the 9-bit data+parity field has even or odd count of ones respectively.
  - Hold for BAUD_CLOCKS cycles, then go to STOP.
- STOP:
  - Drive 1 for BAUD_CLOCKS cycles, then go to IDLE.
  - busy falls on the same edge that enters IDLE.
- Frame length: exactly 11*BAUD_CLOCKS cycles from the edge accepting send to the edge busy falls.
- Baud counter:
  - Counts 0..BAUD_CLOCKS-1, wrapping on each bit boundary.
  - Width is clog2(BAUD_CLOCKS).
  - Every bit is exactly BAUD_CLOCKS cycles.
- send or din changes during a frame are ignored.
- send still high when returning to IDLE: a new frame starts on the next edge. Back-to-back frames are permitted; the line is high for one cycle between them.
- send high coincident with rst: reset wins; state stays IDLE.
- tx_out comes directly from a flop, so the line is glitch-free.

Test Plan:
- Reset:
  - Stimulus: assert rst 80 ns, release on a falling edge.
  - Required: next cycle tx_out=1, busy=0, both stable for 10 us with send=0.
- Single byte 0xA5, PARITY=0:
  - Stimulus: pulse send until busy rises.
  - Required line sequence, each bit 5208 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, 1.
  - busy high for exactly 11*5208 cycles. A serial receiver model decodes 0xA5 with no parity error.
- Odd parity, PARITY=1, byte 0x01: required parity bit 0. Byte 0x00: required parity bit 1.
- 20 random bytes:
  - Stimulus: each byte sent with 1000–30000 idle cycles between frames.
  - Required: every byte decoded correctly by the receiver model; no framing or parity error flagged.
- Reset mid-frame:
  - Stimulus: send 0xA5, wait 4*5208 cycles (inside DATA), pulse rst 20 ns.
  - Required: within 2 cycles after release tx_out=1, busy=0. Line stays high for a further 4 baud periods.
- send held high across frames:
  - Stimulus: hold send=1 for two frames, din=0x3C then 0xC3.
  - Required: two consecutive frames with one high idle cycle between. Second frame carries din sampled at its accept edge.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// Every bit lasts CLK_FREQUENCY/BAUD_RATE cycles; the line idles high.
module uart_tx #(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE     = 19_200,
    parameter int unsigned PARITY        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] din,
    output logic       tx_out,
    output logic       busy
);

    localparam int unsigned BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CNT_W       = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CLOCKS - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] PARITY_BIT = 3'd3;
    localparam logic [2:0] STOP       = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic       bit_done;
    logic       parity_val;
    logic [2:0] idx_next;

    assign bit_done   = (cnt_q == CNT_LAST);
    assign parity_val = (PARITY == 0) ? ^data_q : ~^data_q;
    assign idx_next   = idx_q + 3'd1;

    // Next-state and next-output logic; tx is precomputed so it leaves a flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = 3'd0;
                if (send) begin
                    data_d  = din;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
                        state_d = PARITY_BIT;
                        tx_d    = parity_val;
                    end else begin
                        idx_d = idx_next;
                        tx_d  = data_q[idx_next];
                    end
                end
            end
            PARITY_BIT: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Reset abandons any frame in flight and returns the line high at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one even-parity instance (8 clocks/bit, 1000/115
// truncated) and one odd-parity instance (10 clocks/bit), sharing clock and reset.
module tb_uart_tx;

    localparam int B_E = 8;
    localparam int B_O = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_e, send_o;
    logic [7:0] din_e, din_o;
    logic       tx_e, busy_e, tx_o, busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQUENCY(1000), .BAUD_RATE(115), .PARITY(0)) u_even (
        .clk(clk), .rst(rst), .send(send_e), .din(din_e), .tx_out(tx_e), .busy(busy_e)
    );

    uart_tx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .send(send_o), .din(din_o), .tx_out(tx_o), .busy(busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit odd, input logic s, input logic [7:0] d);
        if (odd) begin
            send_o = s;
            din_o  = d;
        end else begin
            send_e = s;
            din_e  = d;
        end
    endtask

    // Offer a byte on a falling edge; returns right after the accepting rising edge
    task automatic start(input bit odd, input logic [7:0] b);
        @(negedge clk);
        drive(odd, 1'b1, b);
        @(posedge clk);
    endtask

    // Called just after the accept edge: checks every cycle of the frame against
    // the expected waveform, decodes mid-bit like a receiver, then checks idle.
    task automatic monitor(input bit odd, input logic [7:0] b, input logic par,
                           input logic nsend, input logic [7:0] ndin, input string tag);
        int          bc;
        int          bad;
        logic [10:0] frame;
        logic [10:0] rx;
        logic        l;
        logic        bz;
        bc    = odd ? B_O : B_E;
        bad   = 0;
        frame = {1'b1, par, b, 1'b0};
        rx    = '0;
        for (int j = 0; j < 11 * bc; j++) begin
            @(negedge clk);
            if (j == 0) drive(odd, nsend, ndin);
            l  = odd ? tx_o : tx_e;
            bz = odd ? busy_o : busy_e;
            if (l !== frame[j / bc] || bz !== 1'b1) bad++;
            if (j % bc == bc / 2) rx[j / bc] = l;
        end
        check({tag, " wave"}, 32'(bad), 32'd0);
        @(negedge clk);
        l  = odd ? tx_o : tx_e;
        bz = odd ? busy_o : busy_e;
        check({tag, " idle"}, 32'({bz, l}), 32'd1);
        check({tag, " data"}, 32'(rx[8:1]), 32'(b));
        check({tag, " parity_bit"}, 32'(rx[9]), 32'(par));
        check({tag, " parity_err"}, 32'(^rx[9:1]), 32'(odd));
        check({tag, " framing"}, 32'({rx[10], rx[0]}), 32'd2);
    endtask

    initial begin
        int          bad;
        logic [7:0]  b;
        logic        par;
        bit          odd;

        rst    = 1'b1;
        send_e = 1'b0;
        send_o = 1'b0;
        din_e  = 8'h00;
        din_o  = 8'h00;

        // send raised while reset is held: reset must win
        repeat (5) @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        check("rst_with_send", 32'({busy_e, tx_e}), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        check("reset_even", 32'({busy_e, tx_e}), 32'd1);
        check("reset_odd", 32'({busy_o, tx_o}), 32'd1);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ({busy_e, tx_e, busy_o, tx_o} !== 4'b0101) bad++;
        end
        check("reset_stable", 32'(bad), 32'd0);

        // 0xA5 even parity: 0, 1,0,1,0,0,1,0,1, 0, 1
        start(1'b0, 8'hA5);
        monitor(1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, "a5_even");

        // odd parity instance
        start(1'b1, 8'h01);
        monitor(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, "odd_01");
        start(1'b1, 8'h00);
        monitor(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, "odd_00");
        start(1'b1, 8'hA5);
        monitor(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, "odd_a5");

        // reset inside the DATA phase
        start(1'b0, 8'hA5);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00);
        repeat (4 * B_E - 1) @(negedge clk);
        check("mid_busy_before_rst", 32'(busy_e), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_idle", 32'({busy_e, tx_e}), 32'd1);
        bad = 0;
        for (int i = 0; i < 4 * B_E; i++) begin
            @(negedge clk);
            if ({busy_e, tx_e} !== 2'b01) bad++;
        end
        check("mid_rst_line_high", 32'(bad), 32'd0);

        // send held high: back-to-back frames, din change mid-frame ignored
        start(1'b0, 8'h3C);
        monitor(1'b0, 8'h3C, 1'b0, 1'b1, 8'hC3, "b2b_first");
        @(posedge clk);
        monitor(1'b0, 8'hC3, 1'b0, 1'b0, 8'h00, "b2b_second");

        // random bytes on alternating instances with random idle gaps
        for (int i = 0; i < 20; i++) begin
            odd = (i % 2 == 1);
            b   = 8'($urandom);
            par = odd ? ~^b : ^b;
            start(odd, b);
            monitor(odd, b, par, 1'b0, 8'h00, "random");
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
